// File: rtl/sdram_pattern_test.sv
// Self-test initiator for the SDRAM host port: writes a pattern, reads it back and compares.
// Define SDRAM_PATTERN_LFSR_EN for a 16-bit LFSR pattern (DATA_WIDTH must be 16).
module sdram_pattern_test #(
    parameter int ADDR_WIDTH = 23,
    parameter int DATA_WIDTH = 16,
    parameter int ERR_WIDTH  = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] lastAddr_i,
    input  logic [DATA_WIDTH-1:0] seed_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  pass_o,
    output logic [ERR_WIDTH-1:0]  errCnt_o,
    output logic [ADDR_WIDTH-1:0] firstErrAddr_o,
    output logic                  rd_o,
    output logic                  wr_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  opBegun_i,
    input  logic                  done_i,
    input  logic                  rdDone_i,
    input  logic [DATA_WIDTH-1:0] data_i
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0]  ERR_ONE  = ERR_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] last_q;
    logic [DATA_WIDTH-1:0] seed_q;
    logic                  cmpl_pend;
    logic [DATA_WIDTH-1:0] rd_data_q;

    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic                  at_last;
    logic                  start_acc;
    logic                  wr_cmpl;
    logic                  rd_cmpl;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  err_full;
    logic [DATA_WIDTH-1:0] start_pat;
    logic [DATA_WIDTH-1:0] cur_pat;
    logic [DATA_WIDTH-1:0] nxt_pat;

    assign addr_nxt  = addr_o + ADDR_ONE;
    assign at_last   = (addr_o == last_q);
    assign start_acc = (state == IDLE) && start_i;
    // A completion that arrived together with opBegun_i is replayed from cmpl_pend.
    assign wr_cmpl   = (state == WR_WAIT) && (done_i || cmpl_pend);
    assign rd_cmpl   = (state == RD_WAIT) && (rdDone_i || cmpl_pend);
    assign rd_word   = cmpl_pend ? rd_data_q : data_i;
    assign err_full  = &errCnt_o;

`ifdef SDRAM_PATTERN_LFSR_EN
    logic [15:0] lfsr_q;

    function automatic logic [15:0] lfsr_seed(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    always_comb begin
        start_pat = DATA_WIDTH'(lfsr_seed(16'(seed_i)));
        cur_pat   = DATA_WIDTH'(lfsr_q);
        nxt_pat   = DATA_WIDTH'(lfsr_step(lfsr_q));
    end

    // lfsr_q always holds the pattern of the word at addr_o.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= 16'h0001;
        end else if (start_acc) begin
            lfsr_q <= lfsr_seed(16'(seed_i));
        end else if (wr_cmpl) begin
            lfsr_q <= at_last ? lfsr_seed(16'(seed_q)) : lfsr_step(lfsr_q);
        end else if (rd_cmpl) begin
            lfsr_q <= lfsr_step(lfsr_q);
        end
    end
`else
    localparam int PW = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;

    function automatic logic [DATA_WIDTH-1:0] addr_pat(
        input logic [ADDR_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] s
    );
        logic [PW-1:0] ext;
        ext = PW'(a);
        return ext[DATA_WIDTH-1:0] ^ s;
    endfunction

    always_comb begin
        start_pat = addr_pat('0, seed_i);
        cur_pat   = addr_pat(addr_o, seed_q);
        nxt_pat   = addr_pat(addr_nxt, seed_q);
    end
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            last_q         <= '0;
            seed_q         <= '0;
            cmpl_pend      <= 1'b0;
            rd_data_q      <= '0;
            busy_o         <= 1'b0;
            done_o         <= 1'b0;
            pass_o         <= 1'b0;
            errCnt_o       <= '0;
            firstErrAddr_o <= '0;
            rd_o           <= 1'b0;
            wr_o           <= 1'b0;
            addr_o         <= '0;
            data_o         <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_i) begin
                        last_q         <= lastAddr_i;
                        seed_q         <= seed_i;
                        errCnt_o       <= '0;
                        firstErrAddr_o <= '0;
                        done_o         <= 1'b0;
                        pass_o         <= 1'b0;
                        busy_o         <= 1'b1;
                        addr_o         <= '0;
                        data_o         <= start_pat;
                        wr_o           <= 1'b1;
                        cmpl_pend      <= 1'b0;
                        state          <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (opBegun_i) begin
                        wr_o      <= 1'b0;
                        cmpl_pend <= done_i;
                        state     <= WR_WAIT;
                    end
                end
                WR_WAIT: begin
                    if (wr_cmpl) begin
                        cmpl_pend <= 1'b0;
                        if (at_last) begin
                            addr_o <= '0;
                            rd_o   <= 1'b1;
                            state  <= RD_REQ;
                        end else begin
                            addr_o <= addr_nxt;
                            data_o <= nxt_pat;
                            wr_o   <= 1'b1;
                            state  <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (opBegun_i) begin
                        rd_o      <= 1'b0;
                        cmpl_pend <= rdDone_i;
                        rd_data_q <= data_i;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (rd_cmpl) begin
                        cmpl_pend <= 1'b0;
                        if (rd_word != cur_pat) begin
                            if (!err_full) begin
                                errCnt_o <= errCnt_o + ERR_ONE;
                            end
                            if (errCnt_o == '0) begin
                                firstErrAddr_o <= addr_o;
                            end
                        end
                        if (at_last) begin
                            state <= FINISH;
                        end else begin
                            addr_o <= addr_nxt;
                            rd_o   <= 1'b1;
                            state  <= RD_REQ;
                        end
                    end
                end
                FINISH: begin
                    busy_o <= 1'b0;
                    done_o <= 1'b1;
                    pass_o <= (errCnt_o == '0);
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_pattern_test.sv
// Bench for sdram_pattern_test: controller responder, vector table, random runs vs. reference model.
module tb_sdram_pattern_test;

    localparam int AW      = 23;
    localparam int DW      = 16;
    localparam int EW      = 2;
    localparam int CYC_MAX = 6000;

    logic          clkDut = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [AW-1:0] lastAddr_i;
    logic [DW-1:0] seed_i;
    logic          busy_o;
    logic          done_o;
    logic          pass_o;
    logic [EW-1:0] errCnt_o;
    logic [AW-1:0] firstErrAddr_o;
    logic          rd_o;
    logic          wr_o;
    logic [AW-1:0] addr_o;
    logic [DW-1:0] data_o;
    logic          opBegun_i;
    logic          done_i;
    logic          rdDone_i;
    logic [DW-1:0] data_i;

    sdram_pattern_test #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .ERR_WIDTH (EW)
    ) dut (
        .clk_i         (clkDut),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .lastAddr_i    (lastAddr_i),
        .seed_i        (seed_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pass_o        (pass_o),
        .errCnt_o      (errCnt_o),
        .firstErrAddr_o(firstErrAddr_o),
        .rd_o          (rd_o),
        .wr_o          (wr_o),
        .addr_o        (addr_o),
        .data_o        (data_o),
        .opBegun_i     (opBegun_i),
        .done_i        (done_i),
        .rdDone_i      (rdDone_i),
        .data_i        (data_i)
    );

    always #5 clkDut = ~clkDut;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Responder configuration and observation
    int            acc_dly;
    int            cmp_dly;
    bit            spur;
    bit            rd_stuck;
    bit            both_seen;
    bit            withdrawn;
    logic [15:0]   mask [64];
    logic [15:0]   mem  [64];
    logic [AW-1:0] wr_addr[$];
    logic [15:0]   wr_data[$];
    logic [AW-1:0] rd_log[$];

    function automatic logic [15:0] pat(input int a, input logic [15:0] s);
        logic [15:0] r;
`ifdef SDRAM_PATTERN_LFSR_EN
        r = (s == 16'h0000) ? 16'h0001 : s;
        for (int i = 0; i < a; i++) r = {r[14:0], r[15] ^ r[13] ^ r[12] ^ r[10]};
`else
        r = 16'(a) ^ s;
`endif
        return r;
    endfunction

    task automatic model(input int last, input logic [15:0] s, output int ee,
                         output int ef, output bit ep);
        int          cnt;
        logic [15:0] rv;
        cnt = 0;
        ef  = 0;
        for (int a = 0; a <= last; a++) begin
            rv = rd_stuck ? 16'h0000 : (pat(a, s) ^ mask[a]);
            if (rv != pat(a, s)) begin
                if (cnt == 0) ef = a;
                cnt++;
            end
        end
        ee = (cnt > 3) ? 3 : cnt;
        ep = (cnt == 0);
    endtask

    task automatic set_mode(input int mode);
        rd_stuck = 1'b0;
        for (int i = 0; i < 64; i++) mask[i] = (mode == 3) ? 16'hFFFF : 16'h0000;
        if (mode == 1) mask[7] = 16'h0001;
        if (mode == 2) rd_stuck = 1'b1;
    endtask

    // Controller model: accept after acc_dly cycles, complete cmp_dly cycles later
    initial begin
        int          phase;
        int          cnt;
        bit          is_rd;
        logic [AW-1:0] op_addr;
        logic [15:0] op_data;
        phase     = 0;
        cnt       = 0;
        is_rd     = 1'b0;
        op_addr   = '0;
        op_data   = '0;
        opBegun_i = 1'b0;
        done_i    = 1'b0;
        rdDone_i  = 1'b0;
        data_i    = '0;
        forever begin
            @(negedge clkDut);
            opBegun_i = 1'b0;
            done_i    = 1'b0;
            rdDone_i  = 1'b0;
            data_i    = 16'($urandom);
            if (wr_o && rd_o) both_seen = 1'b1;
            if (rst_i) begin
                phase = 0;
            end else begin
                if (phase == 0 && (wr_o || rd_o)) begin
                    is_rd   = rd_o;
                    op_addr = addr_o;
                    op_data = data_o;
                    cnt     = acc_dly;
                    phase   = 1;
                end else if (phase != 0) begin
                    cnt--;
                end
                if (phase == 1) begin
                    if ((is_rd ? !rd_o : !wr_o) || addr_o != op_addr ||
                        (!is_rd && data_o != op_data))
                        withdrawn = 1'b1;
                    if (cnt == 0) begin
                        opBegun_i = 1'b1;
                        if (is_rd) begin
                            rd_log.push_back(op_addr);
                        end else begin
                            wr_addr.push_back(op_addr);
                            wr_data.push_back(op_data);
                            mem[op_addr[5:0]] = op_data;
                        end
                        cnt   = cmp_dly;
                        phase = 2;
                    end else if (spur && $urandom_range(0, 2) == 0) begin
                        done_i   = 1'b1;
                        rdDone_i = 1'b1;
                    end
                end
                if (phase == 2 && cnt == 0) begin
                    if (is_rd) begin
                        rdDone_i = 1'b1;
                        data_i   = rd_stuck ? 16'h0000
                                 : (mem[op_addr[5:0]] ^ mask[op_addr[5:0]]);
                    end else begin
                        done_i = 1'b1;
                    end
                    phase = 0;
                end
            end
        end
    end

    task automatic clear_logs();
        wr_addr.delete();
        wr_data.delete();
        rd_log.delete();
        both_seen = 1'b0;
        withdrawn = 1'b0;
    endtask

    task automatic pulse_start(input int last, input logic [15:0] s);
        @(negedge clkDut);
        lastAddr_i = AW'(last);
        seed_i     = s;
        start_i    = 1'b1;
        @(negedge clkDut);
        start_i    = 1'b0;
    endtask

    task automatic run_vec(input string nm, input int last, input logic [15:0] s,
                           input int acc, input int cmpd, input int ee,
                           input int ef, input bit ep, input bit poke);
        int n;
        int bad;
        acc_dly = acc;
        cmp_dly = cmpd;
        clear_logs();
        pulse_start(last, s);
        check({nm, ".busy"}, busy_o, 1);
        check({nm, ".done_clr"}, done_o, 0);
        n = 0;
        while (!done_o && n < CYC_MAX) begin
            @(negedge clkDut);
            n++;
            start_i = poke && (n == 6);
            if (start_i) lastAddr_i = AW'(last + 20);
        end
        start_i = 1'b0;
        check({nm, ".finished"}, done_o, 1);
        check({nm, ".busy_end"}, busy_o, 0);
        check({nm, ".pass"}, pass_o, ep);
        check({nm, ".errCnt"}, errCnt_o, ee);
        check({nm, ".firstErr"}, firstErrAddr_o, ef);
        check({nm, ".n_writes"}, wr_addr.size(), last + 1);
        check({nm, ".n_reads"}, rd_log.size(), last + 1);
        bad = 0;
        foreach (wr_addr[i]) if (wr_addr[i] != AW'(i) || wr_data[i] != pat(i, s)) bad++;
        foreach (rd_log[i]) if (rd_log[i] != AW'(i)) bad++;
        check({nm, ".sequence"}, bad, 0);
        check({nm, ".rd_wr_excl"}, both_seen, 0);
        check({nm, ".req_stable"}, withdrawn, 0);
        repeat (3) @(negedge clkDut);
        check({nm, ".done_hold"}, done_o, 1);
    endtask

    typedef struct {
        int          last;
        logic [15:0] seed;
        int          acc;
        int          cmpd;
        int          mode;
        int          ee;
        int          ef;
        bit          ep;
        bit          poke;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int          n;
        int          last;
        logic [15:0] s;
        int          ee;
        int          ef;
        bit          ep;

        tbl[0] = '{15, 16'hA5A5, 2, 4, 0, 0, 0, 1'b1, 1'b0};
        tbl[1] = '{15, 16'hA5A5, 2, 4, 1, 1, 7, 1'b0, 1'b0};
`ifdef SDRAM_PATTERN_LFSR_EN
        tbl[2] = '{3, 16'h0000, 2, 4, 2, 3, 0, 1'b0, 1'b0};
`else
        tbl[2] = '{3, 16'h0000, 2, 4, 2, 3, 1, 1'b0, 1'b0};
`endif
        tbl[3] = '{9, 16'h1234, 2, 4, 3, 3, 0, 1'b0, 1'b0};
        tbl[4] = '{15, 16'h5A5A, 0, 0, 0, 0, 0, 1'b1, 1'b0};
        tbl[5] = '{7, 16'hFFFF, 1, 0, 1, 1, 7, 1'b0, 1'b0};
        tbl[6] = '{0, 16'h0F0F, 2, 4, 0, 0, 0, 1'b1, 1'b0};
        tbl[7] = '{3, 16'h00FF, 1, 1, 0, 0, 0, 1'b1, 1'b1};

        rst_i      = 1'b1;
        start_i    = 1'b0;
        lastAddr_i = '0;
        seed_i     = '0;
        spur       = 1'b0;
        acc_dly    = 2;
        cmp_dly    = 4;
        set_mode(0);
        clear_logs();
        repeat (3) @(negedge clkDut);
        check("reset.rd_wr", {rd_o, wr_o}, 0);
        check("reset.flags", {busy_o, done_o, pass_o}, 0);
        check("reset.err", {errCnt_o, firstErrAddr_o}, 0);
        check("reset.addr_data", {addr_o, data_o}, 0);
        rst_i = 1'b0;

        for (int i = 0; i < 8; i++) begin
            set_mode(tbl[i].mode);
            run_vec($sformatf("tbl%0d", i), tbl[i].last, tbl[i].seed, tbl[i].acc,
                    tbl[i].cmpd, tbl[i].ee, tbl[i].ef, tbl[i].ep, tbl[i].poke);
        end

        // Async reset while waiting for the write of address 2 to complete
        set_mode(0);
        acc_dly = 2;
        cmp_dly = 4;
        clear_logs();
        pulse_start(15, 16'h1111);
        n = 0;
        while (wr_addr.size() < 3 && n < CYC_MAX) begin
            @(negedge clkDut);
            n++;
        end
        check("rstw.reach", wr_addr.size(), 3);
        @(negedge clkDut);
        check("rstw.busy_before", busy_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rstw.rd_wr", {rd_o, wr_o}, 0);
        check("rstw.busy", busy_o, 0);
        check("rstw.addr", addr_o, 0);
        repeat (2) @(negedge clkDut);
        rst_i = 1'b0;

        // Async reset with a read request pending
        acc_dly = 6;
        clear_logs();
        pulse_start(1, 16'h2222);
        n = 0;
        while (!rd_o && n < CYC_MAX) begin
            @(negedge clkDut);
            n++;
        end
        check("rstr.rd_seen", rd_o, 1);
        #2 rst_i = 1'b1;
        #1;
        check("rstr.rd_drop", {rd_o, wr_o, busy_o}, 0);
        repeat (2) @(negedge clkDut);
        rst_i = 1'b0;
        run_vec("post_rst", 0, 16'h0F0F, 2, 4, 0, 0, 1'b1, 1'b0);

`ifdef SDRAM_PATTERN_LFSR_EN
        set_mode(0);
        run_vec("lfsr", 5, 16'h0000, 2, 4, 0, 0, 1'b1, 1'b0);
        check("lfsr.w0", wr_data[0], 16'h0001);
        check("lfsr.w1", wr_data[1], 16'h0002);
`endif

        spur = 1'b1;
        for (int t = 0; t < 12; t++) begin
            last = $urandom_range(0, 31);
            s    = 16'($urandom);
            set_mode(0);
            rd_stuck = ($urandom_range(0, 7) == 0);
            if (t % 3 != 0)
                for (int a = 0; a < 64; a++)
                    if ($urandom_range(0, 5) == 0) mask[a] = 16'($urandom_range(1, 65535));
            model(last, s, ee, ef, ep);
            run_vec($sformatf("rnd%0d", t), last, s, $urandom_range(0, 3),
                    $urandom_range(0, 4), ee, ef, ep, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
